// File: rtl/fifo_stat.sv
// Parametrised synchronous FIFO with occupancy, threshold and sticky error status.
// Supports any depth >= 2 and either a registered or a first-word-fall-through read port.
module fifo_stat #(
    parameter int DataWidth         = 8,
    parameter int Depth             = 16,
    parameter int AlmostFullThresh  = Depth - 2,
    parameter int AlmostEmptyThresh = 2,
    parameter bit Fwft              = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [DataWidth-1:0]         i_wr_data,
    input  logic                         i_rd_en,
    input  logic                         i_clr,
    output logic [DataWidth-1:0]         o_rd_data,
    output logic                         o_rd_valid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_almost_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int CW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);
    localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
    localparam logic [CW-1:0] FullCnt = CW'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 full, empty, rd_acc, wr_acc;

    assign full   = (count_q == FullCnt);
    assign empty  = (count_q == '0);
    assign rd_acc = !i_clr && i_rd_en && !empty;
    // A pop in the same cycle frees the slot a write into a full FIFO needs
    assign wr_acc = !i_clr && i_wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (i_wr_en && full && !rd_acc) ovf_d = 1'b1;
            if (i_rd_en && empty)           unf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_count        = count_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = int'(count_q) >= AlmostFullThresh;
    assign o_almost_empty = int'(count_q) <= AlmostEmptyThresh;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

    if (Fwft) begin : g_fwft
        // Head word is presented directly; zero while empty keeps reset output at 0
        assign o_rd_valid = !empty;
        assign o_rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
        logic [DataWidth-1:0] rd_data_q, rd_data_d;
        logic                 rd_valid_q, rd_valid_d;

        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign o_rd_valid = rd_valid_q;
        assign o_rd_data  = rd_data_q;
    end

endmodule
